processor_control_fsm: RTL and testbench

//  Control unit FSM of the lab processor; the stage directly upstream of the register-file write decoder.

---
 rtl/processor_control_fsm_pkg.sv | 44 ++++
 rtl/processor_control_fsm.sv | 100 ++++++++++
 tb/tb_processor_control_fsm.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/processor_control_fsm_pkg.sv
// Shared definitions for the lab processor control unit: opcodes, state
// encodings, ALU op codes and instruction-register field positions.
package processor_control_fsm_pkg;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // IR[15:12] opcode; LOAD uses [11:4] address and [3:0] Rd;
  // STORE uses [11:8] Ra and [7:0] address; ALU ops use [11:8] [7:4] [3:0].
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RA_MSB    = 11;
  localparam int unsigned RA_LSB    = 8;
  localparam int unsigned RB_MSB    = 7;
  localparam int unsigned RB_LSB    = 4;
  localparam int unsigned RC_MSB    = 3;
  localparam int unsigned RC_LSB    = 0;
  localparam int unsigned LDA_MSB   = 11;
  localparam int unsigned LDA_LSB   = 4;
  localparam int unsigned STA_MSB   = 7;
  localparam int unsigned STA_LSB   = 0;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

endpackage

// File: rtl/processor_control_fsm.sv
// Control unit of the lab processor: fetch/decode/execute sequencing with
// Moore outputs decoded from the state register and the current instruction.
module processor_control_fsm
  import processor_control_fsm_pkg::*;
#(
  parameter int unsigned RF_AW = 4,
  parameter int unsigned D_AW  = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [15:0]      IR,
  output logic             PC_clr,
  output logic             PC_up,
  output logic             IR_ld,
  output logic [D_AW-1:0]  D_addr,
  output logic             D_wr,
  output logic             RF_s,
  output logic [RF_AW-1:0] RF_W_addr,
  output logic             RF_W_en,
  output logic [RF_AW-1:0] RF_Ra_addr,
  output logic [RF_AW-1:0] RF_Rb_addr,
  output logic [2:0]       ALU_s,
  output logic [3:0]       State
);

  state_t state, state_nxt;
  logic [3:0] opcode;

  assign opcode = IR[OP_MSB:OP_LSB];
  assign State  = state;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_INIT;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          default:  state_nxt = S_NOOP;
        endcase
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_PASS;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // LOAD_A holds the address for the synchronous memory read; LOAD_B commits it.
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = D_AW'(IR[LDA_MSB:LDA_LSB]);
        RF_s      = 1'b1;
        RF_W_addr = RF_AW'(IR[RC_MSB:RC_LSB]);
        RF_W_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = D_AW'(IR[STA_MSB:STA_LSB]);
        RF_Ra_addr = RF_AW'(IR[RA_MSB:RA_LSB]);
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RF_AW'(IR[RA_MSB:RA_LSB]);
        RF_Rb_addr = RF_AW'(IR[RB_MSB:RB_LSB]);
        RF_W_addr  = RF_AW'(IR[RC_MSB:RC_LSB]);
        ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_processor_control_fsm.sv
// Directed-vector bench for processor_control_fsm: walks each instruction
// class, HALT, and an asynchronous reset landing inside a LOAD.
module tb_processor_control_fsm;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  processor_control_fsm #(.RF_AW(4), .D_AW(8)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s      (ALU_s),
    .State      (State)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Field order: PC_clr PC_up IR_ld D_addr D_wr RF_s W_addr W_en Ra Rb ALU_s State
  function automatic logic [63:0] ev(input logic pcc, input logic pcu, input logic irl,
                                     input logic [7:0] da, input logic dwr, input logic rfs,
                                     input logic [3:0] wa, input logic we,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [2:0] alu, input logic [3:0] st);
    return 64'({pcc, pcu, irl, da, dwr, rfs, wa, we, ra, rb, alu, st});
  endfunction

  function automatic logic [63:0] outs();
    return 64'({PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s, State});
  endfunction

  localparam logic [63:0] V_INIT   = 64'h1_0000_0000 | 64'd0; // PC_clr only, State=0
  localparam logic [63:0] V_FETCH  = 64'h0_C000_0001;        // PC_up, IR_ld, State=1
  localparam logic [63:0] V_DECODE = 64'h0_0000_0002;
  localparam logic [63:0] V_NOOP   = 64'h0_0000_0003;
  localparam logic [63:0] V_HALT   = 64'h0_0000_0009;

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  always @(negedge Clock) begin
    if (Resetn !== 1'bx) check("dwr_wen_excl", 64'(D_wr & RF_W_en), 64'd0);
  end

  initial begin
    Resetn = 1'b0;
    IR     = 16'h0000;
    @(negedge Clock);
    @(negedge Clock);
    check("reset_vec", outs(), V_INIT);
    check("reset_vec_ev", outs(), ev(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'b000,4'd0));
    Resetn = 1'b1;
    step(); check("t1_fetch", outs(), V_FETCH);
    step(); check("t1_decode", outs(), V_DECODE);
    step(); check("t1_noop", outs(), V_NOOP);
    step(); check("t1_fetch2", outs(), V_FETCH);

    IR = 16'h21B5;
    step(); check("t2_decode", outs(), V_DECODE);
    step(); check("t2_load_a", outs(), ev(0,0,0,8'h1B,0,1,4'h5,0,4'h0,4'h0,3'b000,4'd4));
    step(); check("t2_load_b", outs(), ev(0,0,0,8'h1B,0,1,4'h5,1,4'h0,4'h0,3'b000,4'd5));
    step(); check("t2_fetch", outs(), V_FETCH);

    IR = 16'h1A2C;
    step(); check("t3_decode", outs(), V_DECODE);
    step(); check("t3_store", outs(), ev(0,0,0,8'h2C,1,0,4'h0,0,4'hA,4'h0,3'b000,4'd6));
    step(); check("t3_fetch", outs(), V_FETCH);

    IR = 16'h3127;
    step(); check("t4_decode_add", outs(), V_DECODE);
    step(); check("t4_add", outs(), ev(0,0,0,8'h00,0,0,4'h7,1,4'h1,4'h2,3'b001,4'd7));
    step(); check("t4_fetch", outs(), V_FETCH);
    IR = 16'h4127;
    step(); check("t4_decode_sub", outs(), V_DECODE);
    step(); check("t4_sub", outs(), ev(0,0,0,8'h00,0,0,4'h7,1,4'h1,4'h2,3'b010,4'd8));
    step(); check("t4_fetch2", outs(), V_FETCH);

    IR = 16'h7ABC; // undefined opcode behaves as NOOP
    step(); check("undef_decode", outs(), V_DECODE);
    step(); check("undef_noop", outs(), V_NOOP);
    step(); check("undef_fetch", outs(), V_FETCH);

    IR = 16'h5000;
    step(); check("t5_decode", outs(), V_DECODE);
    for (int i = 0; i < 20; i++) begin
      step(); check("t5_halt", outs(), V_HALT);
    end
    #2 Resetn = 1'b0;
    #1 check("t5_reset_async", outs(), V_INIT);
    step(); check("t5_reset_hold", outs(), V_INIT);
    Resetn = 1'b1;
    IR = 16'h0000;
    step(); check("t5_fetch", outs(), V_FETCH);

    IR = 16'h2FF3;
    step(); check("t6_decode", outs(), V_DECODE);
    step(); check("t6_load_a", outs(), ev(0,0,0,8'hFF,0,1,4'h3,0,4'h0,4'h0,3'b000,4'd4));
    #2 Resetn = 1'b0;
    #1 check("t6_reset_async", outs(), V_INIT);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_wen", 64'(RF_W_en), 64'd0);
      check("t6_reset_hold", outs(), V_INIT);
    end
    Resetn = 1'b1;
    step(); check("t6_fetch", outs(), V_FETCH);
    step(); check("t6_decode2", outs(), V_DECODE);
    step(); check("t6_load_a2", outs(), ev(0,0,0,8'hFF,0,1,4'h3,0,4'h0,4'h0,3'b000,4'd4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
